// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and types: coefficient width, transform size,
// twiddle generator state encoding.
package ntt_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned N      = 8;
  localparam int unsigned LOGN   = 3;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef logic [WIDTH-1:0] coef_t;
  typedef logic [LOGN:0]    idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiply (a * b) % q at double width; shared with the
// butterfly network.
module mod_mul
  import ntt_pkg::*;
(
  input  coef_t a,
  input  coef_t b,
  input  coef_t q,
  output coef_t p_c
);

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] rem;

  assign prod = PROD_W'(a) * PROD_W'(b);

  // Guard against q == 0 (only possible while idle after reset).
  assign rem = (q == '0) ? '0 : (prod % PROD_W'(q));
  assign p_c = WIDTH'(rem);

endmodule

// File: rtl/twiddle_gen_8point.sv
// Sequential twiddle table generator: omegas[k] = omega^k mod q, one multiply
// per cycle, plus a primitive-N-th-root flag.
module twiddle_gen_8point
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  coef_t             omega,
  input  coef_t             mod,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              prim_ok,
  output coef_t [N-1:0]     omegas
);

  localparam idx_t            N_IDX    = idx_t'(N);
  localparam logic [LOGN-1:0] HALF_IDX = LOGN'(N / 2);

  state_e        state_q,   state_d;
  idx_t          k_q,       k_d;
  coef_t         omega_r_q, omega_r_d;
  coef_t         mod_r_q,   mod_r_d;
  coef_t [N-1:0] omegas_q,  omegas_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          err_q,     err_d;
  logic          prim_ok_q, prim_ok_d;

  logic [LOGN-1:0] rd_idx;
  logic [LOGN-1:0] wr_idx;
  coef_t           mul_c;

  // At k == N the read index wraps to N-1, giving omega^N for the primitivity test.
  assign rd_idx = LOGN'(k_q - idx_t'(1));
  assign wr_idx = LOGN'(k_q);

  mod_mul u_mod_mul (
    .a   (omegas_q[rd_idx]),
    .b   (omega_r_q),
    .q   (mod_r_q),
    .p_c (mul_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    omega_r_d = omega_r_q;
    mod_r_d   = mod_r_q;
    omegas_d  = omegas_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    prim_ok_d = prim_ok_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (mod == '0) begin
            err_d = 1'b1;
          end else begin
            omega_r_d   = omega % mod;
            mod_r_d     = mod;
            omegas_d    = '0;
            omegas_d[0] = (mod == coef_t'(1)) ? '0 : coef_t'(1);
            k_d         = idx_t'(1);
            busy_d      = 1'b1;
            prim_ok_d   = 1'b0;
            state_d     = CALC;
          end
        end
      end
      CALC: begin
        if (k_q == N_IDX) begin
          prim_ok_d = (mul_c == coef_t'(1)) && (omegas_q[HALF_IDX] != coef_t'(1));
          done_d    = 1'b1;
          busy_d    = 1'b0;
          k_d       = '0;
          state_d   = IDLE;
        end else begin
          omegas_d[wr_idx] = mul_c;
          k_d              = k_q + idx_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      omega_r_q <= '0;
      mod_r_q   <= '0;
      omegas_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      prim_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      omega_r_q <= omega_r_d;
      mod_r_q   <= mod_r_d;
      omegas_q  <= omegas_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      prim_ok_q <= prim_ok_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign prim_ok = prim_ok_q;
  assign omegas  = omegas_q;

endmodule

// File: tb/tb_twiddle_gen_8point.sv
// Scoreboard bench for twiddle_gen_8point: expected tables come from a
// power-by-repeated-multiplication model; a monitor checks each done pulse.
module tb_twiddle_gen_8point;
  import ntt_pkg::*;

  typedef logic [N-1:0][WIDTH-1:0] tab_t;
  typedef struct {
    tab_t tab;
    bit   prim;
    int   acc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  start = 1'b0;
  coef_t omega_i = '0;
  coef_t mod_i = '0;
  logic  busy, done, err, prim_ok;
  tab_t  omegas;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  exp_t  sb[$];
  exp_t  mon_e;
  tab_t  last_tab = '0;
  bit    last_prim = 1'b0;
  tab_t  ref_2_17;
  int    primes[4] = '{17, 97, 193, 241};

  twiddle_gen_8point dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .omega   (omega_i),
    .mod     (mod_i),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .prim_ok (prim_ok),
    .omegas  (omegas)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int powmod(input int w, input int e, input int q);
    int r;
    r = 1 % q;
    for (int j = 0; j < e; j++) r = (r * w) % q;
    return r;
  endfunction

  function automatic exp_t model(input int w, input int q, input int acc);
    exp_t e;
    e.tab = '0;
    for (int k = 0; k < N; k++) e.tab[k] = WIDTH'(powmod(w, k, q));
    e.prim = (powmod(w, N, q) == 1) && (powmod(w, N / 2, q) != 1);
    e.acc  = acc;
    return e;
  endfunction

  // Monitor: every done pulse pops one expectation.
  initial forever begin
    @(negedge clk);
    if (rst_n && done) begin
      done_cnt++;
      chk("busy_low_with_done", 64'(busy), 64'(0));
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(1), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("omegas", 64'(omegas), 64'(mon_e.tab));
        chk("prim_ok", 64'(prim_ok), 64'(mon_e.prim));
        chk("latency", 64'(cyc - mon_e.acc), 64'(N));
      end
    end
  end

  // Issue a start at the current negedge; returns at the negedge after the start edge.
  task automatic issue(input int w, input int q);
    exp_t e;
    start   = 1'b1;
    omega_i = coef_t'(w);
    mod_i   = coef_t'(q);
    @(negedge clk);
    start   = 1'b0;
    omega_i = coef_t'($urandom);
    mod_i   = coef_t'($urandom);
    if (q == 0) begin
      chk("err_pulse", 64'(err), 64'(1));
      chk("busy_on_err", 64'(busy), 64'(0));
      chk("table_kept_on_err", 64'(omegas), 64'(last_tab));
      chk("prim_kept_on_err", 64'(prim_ok), 64'(last_prim));
      @(negedge clk);
      chk("err_one_cycle", 64'(err), 64'(0));
    end else begin
      e = model(w, q, cyc);
      sb.push_back(e);
      last_tab  = e.tab;
      last_prim = e.prim;
      chk("busy_after_start", 64'(busy), 64'(1));
      chk("prim_cleared", 64'(prim_ok), 64'(0));
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_timeout", 64'(seen), 64'(1));
  endtask

  initial begin
    int d0, w, q;
    ref_2_17 = {8'd9, 8'd13, 8'd15, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_prim", 64'(prim_ok), 64'(0));
    chk("rst_omegas", 64'(omegas), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    issue(2, 17);
    wait_done();
    chk("tab_2_17", 64'(omegas), 64'(ref_2_17));
    chk("prim_2_17", 64'(prim_ok), 64'(1));
    repeat (3) @(negedge clk);
    chk("hold_table", 64'(omegas), 64'(ref_2_17));
    chk("hold_busy", 64'(busy), 64'(0));

    issue(4, 17);
    wait_done();
    chk("prim_4_17", 64'(prim_ok), 64'(0));

    issue(19, 17);
    wait_done();
    chk("tab_19_17", 64'(omegas), 64'(ref_2_17));

    issue(5, 1);
    wait_done();
    chk("tab_mod1", 64'(omegas), 64'(0));
    @(negedge clk);
    issue(7, 0);

    // Start while busy is ignored.
    issue(2, 17);
    repeat (2) @(negedge clk);
    start = 1'b1; omega_i = 8'd3; mod_i = 8'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("tab_after_busy_start", 64'(omegas), 64'(ref_2_17));
    repeat (2) @(negedge clk);
    chk("busy_start_not_queued", 64'(busy), 64'(0));

    // Asynchronous reset mid-operation.
    issue(2, 17);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_prim", 64'(prim_ok), 64'(0));
    chk("arst_omegas", 64'(omegas), 64'(0));
    sb.delete();
    last_tab  = '0;
    last_prim = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    chk("no_done_after_reset", 64'(done_cnt), 64'(d0));
    issue(2, 17);
    wait_done();
    chk("tab_after_reset", 64'(omegas), 64'(ref_2_17));

    // Randomized operations, including back-to-back starts on the done cycle.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) q = 0;
      else if ($urandom_range(0, 1) == 1) q = primes[$urandom_range(0, 3)];
      else q = int'($urandom_range(1, 255));
      w = int'($urandom_range(0, 255));
      issue(w, q);
      if (q != 0) wait_done();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
